// File: rtl/control_unit_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: opcodes, FSM state codes,
// datapath select encodings and instruction-class indices.
package control_unit_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  typedef enum logic [3:0] {
    StFetch     = 4'd0,
    StDecode    = 4'd1,
    StExecR     = 4'd2,
    StExecI     = 4'd3,
    StAddr      = 4'd4,
    StMemRd     = 4'd5,
    StMemWr     = 4'd6,
    StWbAlu     = 4'd7,
    StWbMem     = 4'd8,
    StBranch    = 4'd9,
    StJal       = 4'd10,
    StJalr      = 4'd11,
    StExecAuipc = 4'd12,
    StExecLui   = 4'd13,
    StHalt      = 4'd15
  } state_e;

  typedef enum logic [1:0] {
    PcPlus4 = 2'b00,
    PcImm   = 2'b01,
    PcAlu   = 2'b10,
    PcHold  = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    AluAdd   = 2'b00,
    AluPassB = 2'b01,
    AluRType = 2'b10,
    AluIType = 2'b11
  } alu_op_e;

  localparam logic SrcARs1 = 1'b0;
  localparam logic SrcAPc  = 1'b1;
  localparam logic SrcBRs2 = 1'b0;
  localparam logic SrcBImm = 1'b1;

  // Bit positions in the instruction-class one-hot.
  localparam int unsigned ClsR       = 0;
  localparam int unsigned ClsImm     = 1;
  localparam int unsigned ClsLoad    = 2;
  localparam int unsigned ClsStore   = 3;
  localparam int unsigned ClsBranch  = 4;
  localparam int unsigned ClsJal     = 5;
  localparam int unsigned ClsJalr    = 6;
  localparam int unsigned ClsAuipc   = 7;
  localparam int unsigned ClsLui     = 8;
  localparam int unsigned ClsIllegal = 9;
  localparam int unsigned NumCls     = 10;

endpackage

// File: rtl/control_unit_decoder.sv
// Combinational opcode to instruction-class one-hot; exactly one bit is always set,
// with unrecognised opcodes landing on the illegal class.
module cu_decoder
  import control_unit_pkg::*;
(
  input  logic [6:0]        opcode_i,
  output logic [NumCls-1:0] cls_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OpR:      cls_o[ClsR]       = 1'b1;
      OpImm:    cls_o[ClsImm]     = 1'b1;
      OpLoad:   cls_o[ClsLoad]    = 1'b1;
      OpStore:  cls_o[ClsStore]   = 1'b1;
      OpBranch: cls_o[ClsBranch]  = 1'b1;
      OpJal:    cls_o[ClsJal]     = 1'b1;
      OpJalr:   cls_o[ClsJalr]    = 1'b1;
      OpAuipc:  cls_o[ClsAuipc]   = 1'b1;
      OpLui:    cls_o[ClsLui]     = 1'b1;
      default:  cls_o[ClsIllegal] = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle RV32I control FSM. Define CU_ILLEGAL_HALT_EN to send illegal opcodes to a
// sticky HALT state; otherwise they retire as a NOP.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        branchOut,
  output logic        memPC,
  output logic        regWrite,
  output logic [3:0]  cstate,
  output logic        dMemRead,
  output logic        dMemWrite,
  output logic        aluSrcA,
  output logic        aluSrcB,
  output logic [1:0]  pcSelect,
  output logic [2:0]  branchOp,
  output logic [1:0]  aluOp,
  output logic        aluOutDataSel
);

  state_e            state_q, state_d;
  logic [NumCls-1:0] cls;
  pc_sel_e           pc_sel;
  alu_op_e           alu_op;

  logic unused_instr;
  assign unused_instr = ^{instruction[31:15], instruction[11:7]};

  cu_decoder u_decoder (
    .opcode_i (instruction[6:0]),
    .cls_o    (cls)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    memPC         = 1'b0;
    regWrite      = 1'b0;
    dMemRead      = 1'b0;
    dMemWrite     = 1'b0;
    aluSrcA       = SrcARs1;
    aluSrcB       = SrcBRs2;
    pc_sel        = PcHold;
    branchOp      = 3'b000;
    alu_op        = AluAdd;
    aluOutDataSel = 1'b0;

    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        unique case (1'b1)
          cls[ClsR]:                  state_d = StExecR;
          cls[ClsImm]:                state_d = StExecI;
          cls[ClsLoad], cls[ClsStore]: state_d = StAddr;
          cls[ClsBranch]:             state_d = StBranch;
          cls[ClsJal]:                state_d = StJal;
          cls[ClsJalr]:               state_d = StJalr;
          cls[ClsAuipc]:              state_d = StExecAuipc;
          cls[ClsLui]:                state_d = StExecLui;
          default: begin
`ifdef CU_ILLEGAL_HALT_EN
            state_d = StHalt;
`else
            pc_sel  = PcPlus4;
            state_d = StFetch;
`endif
          end
        endcase
      end
      StExecR: begin
        alu_op  = AluRType;
        state_d = StWbAlu;
      end
      StExecI: begin
        aluSrcB = SrcBImm;
        alu_op  = AluIType;
        state_d = StWbAlu;
      end
      StAddr: begin
        aluSrcB = SrcBImm;
        // IR is stable here, so the class can only be load or store.
        if (cls[ClsLoad]) begin
          state_d = StMemRd;
        end else if (cls[ClsStore]) begin
          state_d = StMemWr;
        end else begin
          state_d = StFetch;
        end
      end
      StMemRd: begin
        dMemRead = 1'b1;
        aluSrcB  = SrcBImm;
        state_d  = StWbMem;
      end
      StMemWr: begin
        dMemWrite = 1'b1;
        aluSrcB   = SrcBImm;
        pc_sel    = PcPlus4;
        state_d   = StFetch;
      end
      StExecAuipc: begin
        aluSrcA = SrcAPc;
        aluSrcB = SrcBImm;
        state_d = StWbAlu;
      end
      StExecLui: begin
        aluSrcB = SrcBImm;
        alu_op  = AluPassB;
        state_d = StWbAlu;
      end
      StWbAlu: begin
        regWrite = 1'b1;
        pc_sel   = PcPlus4;
        state_d  = StFetch;
      end
      StWbMem: begin
        regWrite      = 1'b1;
        aluOutDataSel = 1'b1;
        pc_sel        = PcPlus4;
        state_d       = StFetch;
      end
      StBranch: begin
        branchOp = instruction[14:12];
        pc_sel   = branchOut ? PcImm : PcPlus4;
        state_d  = StFetch;
      end
      StJal: begin
        regWrite = 1'b1;
        memPC    = 1'b1;
        pc_sel   = PcImm;
        state_d  = StFetch;
      end
      StJalr: begin
        regWrite = 1'b1;
        memPC    = 1'b1;
        aluSrcB  = SrcBImm;
        pc_sel   = PcAlu;
        state_d  = StFetch;
      end
`ifdef CU_ILLEGAL_HALT_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StFetch;
    endcase

    // Reset forces the FETCH idle pattern regardless of the current state.
    if (rst) begin
      memPC         = 1'b0;
      regWrite      = 1'b0;
      dMemRead      = 1'b0;
      dMemWrite     = 1'b0;
      aluSrcA       = SrcARs1;
      aluSrcB       = SrcBRs2;
      pc_sel        = PcHold;
      branchOp      = 3'b000;
      alu_op        = AluAdd;
      aluOutDataSel = 1'b0;
    end
  end

  assign cstate   = rst ? StFetch : state_q;
  assign pcSelect = pc_sel;
  assign aluOp    = alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expected outputs are queued as stimulus is
// driven and checked against the DUT half a cycle later.
module tb_control_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        branchOut;
  logic        memPC, regWrite, dMemRead, dMemWrite, aluSrcA, aluSrcB, aluOutDataSel;
  logic [3:0]  cstate;
  logic [1:0]  pcSelect, aluOp;
  logic [2:0]  branchOp;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_pc;
    logic       reg_write;
    logic       d_rd;
    logic       d_wr;
    logic       src_a;
    logic       src_b;
    logic [1:0] pc_sel;
    logic [2:0] br_op;
    logic [1:0] alu_op;
    logic       out_sel;
  } obs_t;

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;

  control_unit dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .branchOut     (branchOut),
    .memPC         (memPC),
    .regWrite      (regWrite),
    .cstate        (cstate),
    .dMemRead      (dMemRead),
    .dMemWrite     (dMemWrite),
    .aluSrcA       (aluSrcA),
    .aluSrcB       (aluSrcB),
    .pcSelect      (pcSelect),
    .branchOp      (branchOp),
    .aluOp         (aluOp),
    .aluOutDataSel (aluOutDataSel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic legal_op(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0010111, 7'b0110111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs for a given state, straight from the per-state output table.
  function automatic obs_t model(input logic [3:0] st, input logic [31:0] ins, input logic br);
    obs_t o;
    o = '0;
    o.st = st;
    o.pc_sel = 2'b11;
    case (st)
      4'd1: begin
`ifndef CU_ILLEGAL_HALT_EN
        if (!legal_op(ins[6:0])) o.pc_sel = 2'b00;
`endif
      end
      4'd2:  o.alu_op = 2'b10;
      4'd3:  begin o.src_b = 1'b1; o.alu_op = 2'b11; end
      4'd4:  o.src_b = 1'b1;
      4'd5:  begin o.d_rd = 1'b1; o.src_b = 1'b1; end
      4'd6:  begin o.d_wr = 1'b1; o.src_b = 1'b1; o.pc_sel = 2'b00; end
      4'd7:  begin o.reg_write = 1'b1; o.pc_sel = 2'b00; end
      4'd8:  begin o.reg_write = 1'b1; o.out_sel = 1'b1; o.pc_sel = 2'b00; end
      4'd9:  begin o.br_op = ins[14:12]; o.pc_sel = br ? 2'b01 : 2'b00; end
      4'd10: begin o.reg_write = 1'b1; o.mem_pc = 1'b1; o.pc_sel = 2'b01; end
      4'd11: begin o.reg_write = 1'b1; o.mem_pc = 1'b1; o.src_b = 1'b1; o.pc_sel = 2'b10; end
      4'd12: begin o.src_a = 1'b1; o.src_b = 1'b1; end
      4'd13: begin o.src_b = 1'b1; o.alu_op = 2'b01; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic compare(input string tag);
    obs_t exp_o, got;
    exp_o = sb.pop_front();
    got = {cstate, memPC, regWrite, dMemRead, dMemWrite, aluSrcA, aluSrcB, pcSelect,
           branchOp, aluOp, aluOutDataSel};
    checks++;
    assert (got === exp_o) else begin
      errors++;
      $error("FAIL %s state %0d: observed %b expected %b", tag, exp_o.st, got, exp_o);
    end
  endtask

  // Drive one instruction for n cycles; seq holds the expected state codes, one per nibble.
  task automatic run(input string tag, input logic [31:0] ins, input logic br,
                     input int n, input logic [31:0] seq);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      instruction = ins;
      branchOut   = br;
      sb.push_back(model(seq[4*i +: 4], ins, br));
      #1;
      compare(tag);
    end
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    rst = 1'b1;
    sb.push_back(model(4'd0, instruction, branchOut));
    #1;
    compare(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    instruction = 32'h0;
    branchOut   = 1'b0;

    reset_check("reset");

    run("add",   32'h002080B3, 1'b0, 4, 32'h0000_7210);
    run("lbu",   32'h00024803, 1'b0, 5, 32'h0008_5410);
    run("store", 32'h02853623, 1'b0, 4, 32'h0000_6410);
    run("bltu_t", 32'h00D36363, 1'b1, 3, 32'h0000_0910);
    run("bltu_n", 32'h00D36363, 1'b0, 3, 32'h0000_0910);
    run("jal",   32'hFFDFF06F, 1'b0, 3, 32'h0000_0A10);
    run("auipc", 32'h00001217, 1'b0, 4, 32'h0000_7C10);
    run("lui",   32'h00001237, 1'b0, 4, 32'h0000_7D10);
    run("jalr",  32'h000080E7, 1'b1, 3, 32'h0000_0B10);

    // Partial add, then reset while in EXEC_R: outputs idle at once, FETCH after the edge.
    run("add_part", 32'h002080B3, 1'b0, 3, 32'h0000_0210);
    reset_check("mid_rst");
    run("after_rst", 32'h00001237, 1'b0, 4, 32'h0000_7D10);

`ifdef CU_ILLEGAL_HALT_EN
    run("illegal", 32'hFFFFFFFF, 1'b0, 6, 32'h00FF_FF10);
    run("halt_hold", 32'h002080B3, 1'b1, 2, 32'h0000_00FF);
`else
    run("illegal", 32'hFFFFFFFF, 1'b0, 2, 32'h0000_0010);
    run("after_nop", 32'h002080B3, 1'b0, 4, 32'h0000_7210);
`endif

    reset_check("final_rst");
    run("fetch_final", 32'h00024803, 1'b0, 2, 32'h0000_0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle FSM control unit for an RV32I core (base integer instructions only).
- Decodes the instruction held in the datapath instruction register (IR).
- Sequences FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK phases.
- Drives the datapath mux selects, ALU op class, data-memory strobes, register write and next-PC select. Exposes the current state for debug.

Parameters:
- none; opcodes and state codes are package constants.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instruction  in  32  IR contents; stable from DECODE until the instruction's last state
- branchOut  in  1  branch comparator result (1 = condition true)
- memPC  out  1  writeback data = PC+4 (link for JAL/JALR)
- regWrite  out  1  register-file write enable
- cstate  out  4  current FSM state code
- dMemRead  out  1  data-memory read strobe
- dMemWrite  out  1  data-memory write strobe
- aluSrcA  out  1  ALU A select: 0 = rs1, 1 = PC
- aluSrcB  out  1  ALU B select: 0 = rs2, 1 = immediate
- pcSelect  out  2  next PC: 00 = PC+4, 01 = PC+imm, 10 = {ALUresult[31:1],0}, 11 = hold
- branchOp  out  3  comparator function (funct3)
- aluOp  out  2  00 ADD, 01 PASS_B, 10 R-type funct decode, 11 I-type funct decode
- aluOutDataSel  out  1  writeback data: 0 = ALUOut register, 1 = data-memory read data (ignored when memPC=1)

Behaviour:
- Reset: synchronous. When rst=1 at a clock edge, state <= FETCH (0).
- While rst is high, all outputs take FETCH idle values.
- Default output values in every state unless listed: all 1-bit outputs 0, pcSelect=11, branchOp=000, aluOp=00.
- State codes: 0 FETCH, 1 DECODE, 2 EXEC_R, 3 EXEC_I, 4 ADDR, 5 MEM_RD, 6 MEM_WR, 7 WB_ALU, 8 WB_MEM, 9 BRANCH, 10 JAL, 11 JALR, 12 EXEC_AUIPC, 13 EXEC_LUI, 15 HALT. Code 14 is unused and goes to FETCH.
- FETCH: the datapath loads IR while cstate==0. Next state is DECODE.
- DECODE: branches on opcode = instruction[6:0]:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0010111 -> EXEC_AUIPC
  - 0110111 -> EXEC_LUI
  - any other opcode -> illegal handling (see Optional Feature)
- EXEC_R: aluOp=10. Next WB_ALU.
- EXEC_I: aluSrcB=1, aluOp=11. Next WB_ALU.
- ADDR: aluSrcB=1, aluOp=00. Next MEM_RD if opcode is load, MEM_WR if store.
- MEM_RD: dMemRead=1, aluSrcB=1. Next WB_MEM.
- MEM_WR: dMemWrite=1, aluSrcB=1, pcSelect=00. Next FETCH.
- EXEC_AUIPC: aluSrcA=1, aluSrcB=1, aluOp=00. Next WB_ALU.
- EXEC_LUI: aluSrcB=1, aluOp=01. Next WB_ALU.
- WB_ALU: regWrite=1, pcSelect=00. Next FETCH.
- WB_MEM: regWrite=1, aluOutDataSel=1, pcSelect=00. Next FETCH.
- BRANCH: branchOp=instruction[14:12]. pcSelect=01 if branchOut=1, else 00; this is the only Mealy output. Next FETCH.
- JAL: regWrite=1, memPC=1, pcSelect=01. Next FETCH.
- JALR: regWrite=1, memPC=1, aluSrcB=1, aluOp=00, pcSelect=10. Next FETCH.
- Cycle counts per instruction: R/I/AUIPC/LUI/store 4, load 5, branch/JAL/JALR 3.
- The PC updates only on the edge ending an instruction's last state; it holds otherwise.
- All outputs except pcSelect in BRANCH are a pure function of state and instruction.
- instruction is not registered here; changes mid-instruction affect only the decode of the current state.

Optional Feature:
- Macro: CU_ILLEGAL_HALT_EN.
- Defined: an illegal opcode in DECODE goes to HALT (15). HALT holds all outputs idle (pcSelect=11) and remains there until rst.
- Undefined: an illegal opcode in DECODE drives pcSelect=00 and returns to FETCH, i.e. it executes as a NOP. HALT is unreachable.

Decomposition:
- Package control_unit_pkg:
  - opcode localparams
  - state enum/codes (4-bit)
  - pcSelect, aluOp and aluSrc encodings
- Optional sub-module cu_decoder: combinational opcode -> instruction-class one-hot, used by DECODE and ADDR.

Test Plan:
- rst=1 for 1 cycle, then instruction=32'h002080B3 (add) -> cstate 0,1,2,7,0; regWrite=1 and pcSelect=00 only in state 7; aluOp=10 in state 2.
- instruction=32'h00024803 (lbu) -> cstate 0,1,4,5,8,0; dMemRead=1 in 5; regWrite=1, aluOutDataSel=1 in 8.
- instruction=32'h02853623 (sd-pattern store) -> 0,1,4,6,0; dMemWrite=1, pcSelect=00 in 6; regWrite never 1.
- instruction=32'h00D36363 (bltu) with branchOut=1 -> 0,1,9,0; branchOp=110, pcSelect=01. Repeat with branchOut=0 -> pcSelect=00.
- instruction=32'hFFDFF06F (jal) -> 0,1,10,0 with memPC=1, regWrite=1, pcSelect=01. Then 32'h00001217 (auipc) -> state 12 with aluSrcA=1, aluSrcB=1.
- instruction=32'h00001237 (lui) -> state 13 aluOp=01. Then 32'hFFFFFFFF -> HALT (cstate=15) held if CU_ILLEGAL_HALT_EN, else FETCH with pcSelect=00. Assert rst mid-instruction -> FETCH next edge.
